// File: rtl/bubble_spawner.sv
// Upstream spawner for a pool of bubble movers: queues level/hit requests and issues
// one-cycle start pulses to the lowest free slot, splitting hit bubbles into two children.
module bubble_spawner #(
    parameter int unsigned NUM_SLOTS    = 8,
    parameter int unsigned QUEUE_DEPTH  = 4,
    parameter int unsigned CHILD_OFFSET = 16,
    parameter int unsigned X_MAX        = 639,
    parameter int unsigned Y_MAX        = 479
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 level_start,
    input  logic [2:0]           level_size,
    input  logic [10:0]          level_x,
    input  logic [10:0]          level_y,
    input  logic                 hit_valid,
    input  logic [2:0]           hit_size,
    input  logic [10:0]          hit_x,
    input  logic [10:0]          hit_y,
    input  logic [NUM_SLOTS-1:0] slot_free,
    output logic [NUM_SLOTS-1:0] start,
    output logic [10:0]          startTopX,
    output logic [10:0]          startTopY,
    output logic [2:0]           size_out,
    output logic                 direction,
    output logic                 pop_event,
    output logic                 queue_full,
    output logic                 overflow,
    output logic                 all_cleared
);

    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic        split;
        logic [2:0]  size;
        logic [10:0] x;
        logic [10:0] y;
    } entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSpawnA,
        StHoldA,
        StSpawnB,
        StHoldB
    } state_e;

    state_e state;

    entry_t        mem [2**PW];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic   fifo_empty;
    logic   push_req;
    logic   pop;
    logic   push_ok;
    entry_t head;
    entry_t hit_entry;
    entry_t level_entry;

    logic        w_split;
    logic [2:0]  w_size;
    logic [10:0] w_x;
    logic [10:0] w_y;

    logic [NUM_SLOTS-1:0] sel;
    logic                 any_free;
    logic [11:0]          x_sum;
    logic [10:0]          x_right;
    logic [10:0]          y_clamped;

    assign fifo_empty  = (count == '0);
    assign queue_full  = (count == CW'(QUEUE_DEPTH));
    // level_start wins the cycle: the hit is discarded and the FSM pop is cancelled.
    assign push_req    = !level_start && hit_valid && (hit_size != 3'd0);
    assign pop         = !level_start && (state == StLoad);
    assign push_ok     = push_req && (!queue_full || pop);
    assign head        = mem[rd_ptr];
    assign hit_entry   = {1'b1, hit_size - 3'd1, hit_x, hit_y};
    assign level_entry = {1'b0, level_size, level_x, level_y};

    assign any_free  = |slot_free;
    assign x_sum     = {1'b0, w_x} + 12'(CHILD_OFFSET);
    assign x_right   = (x_sum > 12'(X_MAX)) ? 11'(X_MAX) : x_sum[10:0];
    assign y_clamped = (w_y > 11'(Y_MAX)) ? 11'(Y_MAX) : w_y;

    // Lowest-index free slot wins.
    always_comb begin
        sel = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (slot_free[i]) begin
                sel = NUM_SLOTS'(1) << i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (level_start) begin
            mem[0] <= level_entry;
        end else if (push_ok) begin
            mem[wr_ptr] <= hit_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (level_start) begin
            wr_ptr <= PW'(1);
            rd_ptr <= '0;
            count  <= CW'(1);
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_event   <= 1'b0;
            overflow    <= 1'b0;
            all_cleared <= 1'b0;
        end else begin
            pop_event   <= !level_start && hit_valid && (hit_size == 3'd0);
            all_cleared <= (&slot_free) && fifo_empty && (state == StIdle) &&
                           !push_req && !level_start;
            if (level_start) begin
                overflow <= 1'b0;
            end else if (push_req && queue_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Spawn outputs stay put after each pulse; the mover samples them a cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            start     <= '0;
            startTopX <= '0;
            startTopY <= '0;
            size_out  <= '0;
            direction <= 1'b0;
            w_split   <= 1'b0;
            w_size    <= '0;
            w_x       <= '0;
            w_y       <= '0;
        end else if (level_start) begin
            state <= StIdle;
            start <= '0;
        end else begin
            start <= '0;
            unique case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    w_split <= head.split;
                    w_size  <= head.size;
                    w_x     <= head.x;
                    w_y     <= head.y;
                    state   <= StSpawnA;
                end
                StSpawnA: begin
                    if (any_free) begin
                        start     <= sel;
                        startTopX <= w_x;
                        startTopY <= y_clamped;
                        size_out  <= w_size;
                        direction <= !w_split;
                        state     <= StHoldA;
                    end
                end
                StHoldA: begin
                    state <= w_split ? StSpawnB : StIdle;
                end
                StSpawnB: begin
                    if (any_free) begin
                        start     <= sel;
                        startTopX <= x_right;
                        startTopY <= y_clamped;
                        size_out  <= w_size;
                        direction <= 1'b1;
                        state     <= StHoldB;
                    end
                end
                StHoldB: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
